spinner_quad: RTL and testbench
===============================

SPINNER_QUAD -- requirements
Module: spinner_quad

Interface
REQ-001 Parameter ACC_W, default 10, width of the signed step accumulator.
REQ-002 Parameter DIV_W, default 16, width of the step-rate counter and clkdiv.
REQ-003 CLK  input  1  single clock for all logic; nominally the 6 MHz game clock.
REQ-004 reset  input  1  reset; synchronous, active-high.
REQ-005 spinner  input  9  spinner[7:0] is a signed two's-complement delta; spinner[8] toggles once per new event.
REQ-006 clkdiv  input  DIV_W  CLK cycles per quadrature step; sampled continuously.
REQ-007 steer  output  2  quadrature output: steer[1] = channel A, steer[0] = channel B; registered.
REQ-008 busy  output  1  high while the accumulator is nonzero; registered.

Function
REQ-009 Event detect SHALL register spinner[8] every cycle; an event is current spinner[8] != registered copy.
REQ-010 On an event, the block SHALL sign-extend spinner[7:0] to ACC_W bits and add it to accumulator acc.
REQ-011 Accumulator arithmetic SHALL saturate at +(2^(ACC_W-1)-1) and -(2^(ACC_W-1)-1), i.e. ±511 at default; no wrap-around.
REQ-012 An event with delta 0 SHALL leave acc unchanged.
REQ-013 The step timer SHALL count 0..clkdiv-1 and assert a one-cycle tick when the count equals clkdiv-1, then return to 0.
REQ-014 clkdiv = 0 or 1 SHALL produce a tick every cycle.
REQ-015 A clkdiv decrease below the current count SHALL force a tick on the next cycle and restart the count at 0.
REQ-016 Phase SHALL be a 2-bit Gray state; its forward sequence is 00 -> 01 -> 11 -> 10 -> 00.
REQ-017 On a tick with acc > 0, phase SHALL advance one forward step and acc SHALL decrement by 1.
REQ-018 On a tick with acc < 0, phase SHALL move one reverse step and acc SHALL increment by 1.
REQ-019 On a tick with acc = 0, phase and acc SHALL hold.
REQ-020 Event and tick in the same cycle: acc_next = sat(acc + delta - sign(acc)); the phase direction is taken from the pre-update acc.
REQ-021 steer SHALL equal the phase register; exactly one of steer[1:0] changes per step.
REQ-022 Latency: an event sampled at edge n updates acc at edge n+1; the first resulting steer change is at the first tick after edge n+1.
REQ-023 busy SHALL be registered as (acc_next != 0) and track acc with zero lag.
REQ-024 The timer SHALL free-run regardless of acc, so step spacing is exactly clkdiv cycles while busy.

Reset
REQ-025 While reset is high at a CLK edge, acc SHALL become 0, phase/steer 00, timer 0, busy 0.
REQ-026 While reset is high, the registered copy of spinner[8] SHALL load the current spinner[8], so no spurious event occurs after release.
REQ-027 Reset asserted mid-operation SHALL discard pending steps immediately; no further steer change occurs until a new event.
REQ-028 The first tick after reset release SHALL occur clkdiv cycles after release.

Verification
REQ-029 Scenario: clkdiv=4; toggle spinner[8] with delta +3 -> steer 00->01->11->10 at 4-cycle spacing; busy high for 12 cycles then 0; acc=0.
REQ-030 Scenario: clkdiv=4; delta -2 -> steer 00->10->11; acc returns to 0.
REQ-031 Scenario: 5 consecutive events of +127 with clkdiv=1000 -> acc saturates at +511; busy=1; subsequent steps count down from 511.
REQ-032 Scenario: event and tick coincide with acc=+1 and delta -1 -> acc_next=-1; phase steps forward once; then one reverse step restores the prior phase.
REQ-033 Scenario: reset pulsed while acc=+50 and spinner[8]=1 -> acc=0, steer=00, busy=0; no step for 3*clkdiv cycles afterwards.
REQ-034 Scenario: clkdiv=0 with delta +4 -> four steps on four consecutive cycles, ending at steer=00.

Source files
------------

// File: rtl/spinner_quad.sv
// Spinner-to-quadrature converter: accumulates signed spinner deltas and replays
// them as Gray-coded A/B steps at a programmable step rate.
module spinner_quad #(
  parameter int ACC_W = 10,
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [8:0]       spinner,
  input  logic [DIV_W-1:0] clkdiv,
  output logic [1:0]       steer,
  output logic             busy
);

  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] SUM_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = -SUM_MAX;

  // Symmetric clamp to +/-(2^(ACC_W-1)-1); the most negative code is never produced.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] sum);
    logic signed [SUM_W-1:0] clamped;
    if (sum > SUM_MAX) begin
      clamped = SUM_MAX;
    end else if (sum < SUM_MIN) begin
      clamped = SUM_MIN;
    end else begin
      clamped = sum;
    end
    return clamped[ACC_W-1:0];
  endfunction

  function automatic logic [1:0] gray_fwd(input logic [1:0] p);
    return {p[0], ~p[1]};
  endfunction

  function automatic logic [1:0] gray_rev(input logic [1:0] p);
    return {~p[0], p[1]};
  endfunction

  logic                    tog_q, tog_d;
  logic                    vld_p0_q, vld_p0_d;
  logic signed [7:0]       delta_p0_q, delta_p0_d;
  logic [DIV_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [1:0]              phase_q, phase_d;
  logic                    busy_q, busy_d;

  logic                    tick;
  logic                    acc_neg, acc_nz;
  logic signed [SUM_W-1:0] acc_ext, delta_ext, step_ext, sum;

  always_comb begin
    tog_d      = spinner[8];
    vld_p0_d   = spinner[8] ^ tog_q;
    delta_p0_d = spinner[7:0];

    // >= rather than == so a shrinking clkdiv that skips past the count still ticks.
    tick = (clkdiv <= DIV_W'(1)) || (cnt_q >= (clkdiv - DIV_W'(1)));
    cnt_d = tick ? '0 : cnt_q + DIV_W'(1);

    acc_neg   = acc_q[ACC_W-1];
    acc_nz    = |acc_q;
    acc_ext   = {{2{acc_q[ACC_W-1]}}, acc_q};
    delta_ext = vld_p0_q ? {{(SUM_W-8){delta_p0_q[7]}}, delta_p0_q} : '0;
    step_ext  = '0;
    if (tick && acc_nz) begin
      step_ext = acc_neg ? -SUM_W'(1) : SUM_W'(1);
    end
    sum   = acc_ext + delta_ext - step_ext;
    acc_d = sat_acc(sum);

    // Direction comes from the pre-update accumulator, even when an event lands on a tick.
    phase_d = phase_q;
    if (tick && acc_nz) begin
      phase_d = acc_neg ? gray_rev(phase_q) : gray_fwd(phase_q);
    end

    busy_d = |acc_d;
  end

  // Stage p0: capture event and delta; the toggle copy tracks spinner[8] even in reset.
  always_ff @(posedge CLK) begin
    tog_q      <= tog_d;
    delta_p0_q <= delta_p0_d;
  end

  // Stage p1: accumulate, step timer, quadrature phase.
  always_ff @(posedge CLK) begin
    if (reset) begin
      vld_p0_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      phase_q  <= 2'b00;
      busy_q   <= 1'b0;
    end else begin
      vld_p0_q <= vld_p0_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      phase_q  <= phase_d;
      busy_q   <= busy_d;
    end
  end

  assign steer = phase_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_spinner_quad.sv
// Directed bench for spinner_quad: per-cycle vector table plus saturation sequences.
module tb_spinner_quad;

  logic        CLK = 1'b0;
  logic        reset;
  logic [8:0]  spinner;
  logic [15:0] clkdiv;
  logic [1:0]  steer;
  logic        busy;

  int total = 0;
  int bad   = 0;

  spinner_quad #(.ACC_W(10), .DIV_W(16)) dut (
    .CLK(CLK), .reset(reset), .spinner(spinner), .clkdiv(clkdiv),
    .steer(steer), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [8:0]  sp;
    logic [15:0] cd;
    logic [1:0]  st;
    logic        bz;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int n, input logic r, input logic [8:0] sp,
                              input logic [15:0] cd, input logic [1:0] st, input logic bz);
    vec_t v;
    v.rst = r; v.sp = sp; v.cd = cd; v.st = st; v.bz = bz;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge CLK);
    #1;
  endtask

  task automatic sat_run(input string name, input logic [7:0] delta, input logic [1:0] final_st);
    int steps;
    int cycles;
    logic [1:0] prev;
    reset = 1'b1; spinner = 9'h000; clkdiv = 16'd1000;
    tick_clk();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      spinner = {~spinner[8], delta};
      tick_clk();
    end
    tick_clk();
    chk({name, "_busy"}, 0, busy, 1);
    chk({name, "_steer_hold"}, 0, steer, 2'b00);
    clkdiv = 16'd0;
    prev = steer; steps = 0; cycles = 0;
    while (busy && cycles < 2000) begin
      tick_clk();
      if (steer != prev) steps++;
      prev = steer;
      cycles++;
    end
    chk({name, "_timeout"}, 0, (cycles < 2000), 1);
    chk({name, "_steps"}, 0, steps, 511);
    chk({name, "_final_steer"}, 0, steer, final_st);
  endtask

  initial begin
    reset = 1'b1; spinner = 9'h000; clkdiv = 16'd4;

    // clkdiv=4, +3: event lands on a tick, so busy spans exactly 12 cycles.
    add(2, 1, 9'h000, 4, 2'b00, 0);
    add(2, 0, 9'h000, 4, 2'b00, 0);
    add(1, 0, 9'h103, 4, 2'b00, 0);
    add(4, 0, 9'h103, 4, 2'b00, 1);
    add(4, 0, 9'h103, 4, 2'b01, 1);
    add(4, 0, 9'h103, 4, 2'b11, 1);
    add(5, 0, 9'h103, 4, 2'b10, 0);
    // Reset with spinner[8]=1 held: no spurious event; then -2 reverses 00->10->11.
    add(1, 1, 9'h103, 4, 2'b00, 0);
    add(2, 0, 9'h103, 4, 2'b00, 0);
    add(1, 0, 9'h0FE, 4, 2'b00, 0);
    add(4, 0, 9'h0FE, 4, 2'b00, 1);
    add(4, 0, 9'h0FE, 4, 2'b10, 1);
    add(2, 0, 9'h0FE, 4, 2'b11, 0);
    // clkdiv=0, +4: four steps on consecutive cycles back to 00.
    add(1, 1, 9'h0FE, 0, 2'b00, 0);
    add(1, 0, 9'h104, 0, 2'b00, 0);
    add(1, 0, 9'h104, 0, 2'b00, 1);
    add(1, 0, 9'h104, 0, 2'b01, 1);
    add(1, 0, 9'h104, 0, 2'b11, 1);
    add(1, 0, 9'h104, 0, 2'b10, 1);
    add(2, 0, 9'h104, 0, 2'b00, 0);
    // Event coincides with tick at acc=+1, delta -1: forward then reverse.
    add(1, 1, 9'h104, 0, 2'b00, 0);
    add(1, 0, 9'h001, 0, 2'b00, 0);
    add(1, 0, 9'h1FF, 0, 2'b00, 1);
    add(1, 0, 9'h1FF, 0, 2'b01, 1);
    add(2, 0, 9'h1FF, 0, 2'b00, 0);
    // acc=+50 then reset with spinner[8]=1: quiet for 3*clkdiv cycles.
    add(1, 1, 9'h000, 4, 2'b00, 0);
    add(1, 0, 9'h132, 4, 2'b00, 0);
    add(2, 0, 9'h132, 4, 2'b00, 1);
    add(1, 0, 9'h132, 4, 2'b01, 1);
    add(1, 1, 9'h132, 4, 2'b00, 0);
    add(12, 0, 9'h132, 4, 2'b00, 0);
    // clkdiv drops 8->3 below the count: immediate tick and restart.
    add(1, 1, 9'h000, 8, 2'b00, 0);
    add(1, 0, 9'h10A, 8, 2'b00, 0);
    add(4, 0, 9'h10A, 8, 2'b00, 1);
    add(3, 0, 9'h10A, 3, 2'b01, 1);
    add(1, 0, 9'h10A, 3, 2'b11, 1);
    // Zero-delta event leaves acc unchanged; stepping continues on schedule.
    add(2, 0, 9'h000, 3, 2'b11, 1);
    add(1, 0, 9'h000, 3, 2'b10, 1);
    add(2, 0, 9'h000, 3, 2'b10, 1);
    add(1, 0, 9'h000, 3, 2'b00, 1);

    foreach (vecs[i]) begin
      reset   = vecs[i].rst;
      spinner = vecs[i].sp;
      clkdiv  = vecs[i].cd;
      tick_clk();
      chk("steer", i, steer, vecs[i].st);
      chk("busy", i, busy, vecs[i].bz);
    end

    // 5 x +127 saturates at +511; 5 x -128 saturates at -511.
    sat_run("sat_pos", 8'h7F, 2'b10);
    sat_run("sat_neg", 8'h80, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
